// File: rtl/mac_ctrl_pkg.sv
// Shared definitions for mac_array_ctrl: controller FSM states and the
// two-bit instruction encodings sent to the MAC array.
package mac_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_GAP    = 3'd2,
        ST_EXEC   = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic [1:0] INST_IDLE = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

endpackage

// File: rtl/mac_ctrl_cnt.sv
// Loadable up-counter with synchronous clear and enable; 'hit' flags that
// the current count equals the supplied terminal value.
module mac_ctrl_cnt #(
    parameter int aw = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic          load,
    input  logic [aw-1:0] load_val,
    input  logic [aw-1:0] term,
    output logic [aw-1:0] cnt,
    output logic          hit
);

    logic [aw-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;
    assign hit = (r_cnt == term);

endmodule

// File: rtl/mac_array_ctrl.sv
// Job sequencer for a row x col MAC array: weight load, settle gap, activation
// stream, psum drain. Define MAC_CTRL_PERF_CNT_EN to add the perf_cycles output.
module mac_array_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int row = 8,
    parameter int col = 8,
    parameter int aw  = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [aw-1:0] n_nij,
    output logic          busy,
    output logic          done,
    output logic          w_rd_en,
    output logic [aw-1:0] w_rd_addr,
    output logic          a_rd_en,
    output logic [aw-1:0] a_rd_addr,
    output logic [1:0]    inst_w,
    input  logic [col-1:0] valid_in,
    output logic          psum_wr_en,
    output logic [aw-1:0] psum_wr_addr
`ifdef MAC_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]   perf_cycles
`endif
);

    state_t        r_state;
    state_t        w_state_next;
    logic [aw-1:0] r_n_nij;
    logic [1:0]    r_inst_w;

    logic          w_accept;
    logic          w_rd_active;
    logic          w_rd_clr;
    logic          w_rd_hit;
    logic [aw-1:0] w_rd_term;
    logic [aw-1:0] w_rd_cnt;
    logic          w_beat_window;
    logic          w_beat_fire;
    logic          w_beat_hit;
    logic          w_beat_last;
    logic [aw-1:0] w_beat_cnt;
    logic          w_unused;

    assign w_unused    = (^valid_in) ^ (row > 0);
    assign w_accept    = (r_state == ST_IDLE) && start;
    assign w_rd_active = (r_state == ST_LOAD_W) || (r_state == ST_GAP) || (r_state == ST_EXEC);
    assign w_rd_clr    = (r_state == ST_IDLE) || (w_rd_active && w_rd_hit);
    // One counter paces LOAD_W and GAP (col cycles each) and the EXEC reads.
    assign w_rd_term   = (r_state == ST_EXEC) ? (r_n_nij - aw'(1)) : aw'(col - 1);

    mac_ctrl_cnt #(.aw(aw)) u_rd_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (w_rd_clr),
        .en       (w_rd_active),
        .load     (1'b0),
        .load_val ('0),
        .term     (w_rd_term),
        .cnt      (w_rd_cnt),
        .hit      (w_rd_hit)
    );

    assign w_beat_window = (r_state == ST_EXEC) || (r_state == ST_DRAIN);
    assign w_beat_fire   = w_beat_window && valid_in[col-1] && !w_beat_hit;
    assign w_beat_last   = (w_beat_cnt + aw'(1)) == r_n_nij;

    mac_ctrl_cnt #(.aw(aw)) u_beat_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (r_state == ST_IDLE),
        .en       (w_beat_fire),
        .load     (1'b0),
        .load_val ('0),
        .term     (r_n_nij),
        .cnt      (w_beat_cnt),
        .hit      (w_beat_hit)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (start)    w_state_next = ST_LOAD_W;
            ST_LOAD_W: if (w_rd_hit) w_state_next = ST_GAP;
            ST_GAP:    if (w_rd_hit) w_state_next = (r_n_nij == '0) ? ST_DRAIN : ST_EXEC;
            ST_EXEC:   if (w_rd_hit) w_state_next = ST_DRAIN;
            // Exit as soon as the final beat lands so done follows it by one cycle.
            ST_DRAIN:  if (w_beat_hit || (w_beat_fire && w_beat_last)) w_state_next = ST_DONE;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_n_nij  <= '0;
            r_inst_w <= INST_IDLE;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_n_nij <= n_nij;
            end
            if (w_rd_en) begin
                r_inst_w <= INST_LOAD;
            end else if (a_rd_en) begin
                r_inst_w <= INST_EXEC;
            end else begin
                r_inst_w <= INST_IDLE;
            end
        end
    end

    assign busy         = (r_state != ST_IDLE);
    assign done         = (r_state == ST_DONE);
    assign w_rd_en      = (r_state == ST_LOAD_W);
    assign w_rd_addr    = w_rd_en ? w_rd_cnt : '0;
    assign a_rd_en      = (r_state == ST_EXEC);
    assign a_rd_addr    = a_rd_en ? w_rd_cnt : '0;
    assign inst_w       = r_inst_w;
    assign psum_wr_en   = w_beat_fire;
    assign psum_wr_addr = w_beat_cnt;

`ifdef MAC_CTRL_PERF_CNT_EN
    logic [31:0] r_perf_cycles;

    // The accept cycle itself counts, so the value after done is accept..done inclusive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_cycles <= '0;
        end else if (w_accept) begin
            r_perf_cycles <= 32'd1;
        end else if (busy) begin
            r_perf_cycles <= r_perf_cycles + 32'd1;
        end
    end

    assign perf_cycles = r_perf_cycles;
`endif

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Self-checking bench for mac_array_ctrl: table of jobs plus random jobs, each
// checked cycle by cycle against a timeline model of the job.
module tb_mac_array_ctrl;

    localparam int ROW  = 8;
    localparam int COL  = 8;
    localparam int AW   = 11;
    localparam int MAXC = 320;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [AW-1:0]  n_nij = '0;
    logic [COL-1:0] valid_in = '0;
    logic           busy, done, w_rd_en, a_rd_en, psum_wr_en;
    logic [AW-1:0]  w_rd_addr, a_rd_addr, psum_wr_addr;
    logic [1:0]     inst_w;
`ifdef MAC_CTRL_PERF_CNT_EN
    logic [31:0]    perf_cycles;
`endif

    always #5 clk = ~clk;

    mac_array_ctrl #(.row(ROW), .col(COL), .aw(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .n_nij        (n_nij),
        .busy         (busy),
        .done         (done),
        .w_rd_en      (w_rd_en),
        .w_rd_addr    (w_rd_addr),
        .a_rd_en      (a_rd_en),
        .a_rd_addr    (a_rd_addr),
        .inst_w       (inst_w),
        .valid_in     (valid_in),
        .psum_wr_en   (psum_wr_en),
        .psum_wr_addr (psum_wr_addr)
`ifdef MAC_CTRL_PERF_CNT_EN
        ,
        .perf_cycles  (perf_cycles)
`endif
    );

    typedef struct {
        int n;
        int maxgap;
        bit spur_start;
        int rst_at;
        int exp_done;
        int exp_writes;
    } job_t;

    int n_checks = 0;
    int n_pass   = 0;
    int beat_idx [MAXC];
    bit spur     [MAXC];

    task automatic chk(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got %0h required %0h", name, got, exp);
    endtask

    // Timeline model: the job is accepted in cycle 0. Weight reads occupy
    // cycles 1..COL, the gap COL more, activation reads 2*COL+1..2*COL+n.
    // The array answers each exec instruction with one valid_in beat after a
    // random delay, in order; done is the cycle after the last beat.
    task automatic run_job(input job_t j);
        int prev, b, d, last_c, done_cyc, dones, writes, e_writes;
        bit ab, e_w, e_a, e_p;
        logic [1:0] e_inst;
        logic [39:0] got_v, exp_v;
        for (int c = 0; c < MAXC; c++) begin
            beat_idx[c] = -1;
            spur[c] = 1'b0;
        end
        prev = 0;
        for (int k = 0; k < j.n; k++) begin
            b = 2*COL + 3 + k;
            if (k > 0 && prev + 1 > b) b = prev + 1;
            b += int'($urandom_range(j.maxgap, 0));
            beat_idx[b] = k;
            prev = b;
        end
        d = (j.n == 0) ? 2*COL + 2 : prev + 1;
        for (int c = 1; c <= 2*COL; c++) spur[c] = 1'($urandom_range(1, 0));
        for (int c = d; c <= d + 2; c++) spur[c] = 1'b1;
        last_c = (j.rst_at >= 0) ? j.rst_at + 5 : d + 2;
        done_cyc = -1; dones = 0; writes = 0; e_writes = 0;

        for (int c = 0; c <= last_c; c++) begin
            start    = (c == 0) || (j.spur_start && (c == 2*COL + 3 || c == d));
            n_nij    = (c == 0) ? AW'(j.n) : AW'($urandom);
            valid_in = COL'($urandom);
            valid_in[COL-1] = (beat_idx[c] >= 0) || spur[c];
            if (c == j.rst_at) reset = 1'b0;
            @(negedge clk);
            ab     = (j.rst_at >= 0) && (c >= j.rst_at);
            e_w    = !ab && c >= 1 && c <= COL;
            e_a    = !ab && c >= 2*COL + 1 && c <= 2*COL + j.n;
            e_p    = !ab && beat_idx[c] >= 0;
            e_inst = ab ? 2'b00 :
                     (c >= 2 && c <= COL + 1) ? 2'b01 :
                     (c >= 2*COL + 2 && c <= 2*COL + j.n + 1) ? 2'b10 : 2'b00;
            exp_v = {!ab && c >= 1 && c <= d, !ab && c == d,
                     e_w, e_w ? AW'(c - 1) : AW'(0),
                     e_a, e_a ? AW'(c - 2*COL - 1) : AW'(0),
                     e_inst, e_p, e_p ? AW'(beat_idx[c]) : AW'(0)};
            got_v = {busy, done,
                     w_rd_en, w_rd_en ? w_rd_addr : AW'(0),
                     a_rd_en, a_rd_en ? a_rd_addr : AW'(0),
                     inst_w, psum_wr_en, psum_wr_en ? psum_wr_addr : AW'(0)};
            chk($sformatf("outputs n=%0d cyc%0d", j.n, c), got_v, exp_v);
            if (c == j.rst_at) chk("reset_addrs", {w_rd_addr, a_rd_addr, psum_wr_addr}, 0);
`ifdef MAC_CTRL_PERF_CNT_EN
            if (ab) chk("perf_reset", perf_cycles, 0);
            else if (c > d) chk("perf_hold", perf_cycles, d + 1);
`endif
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (psum_wr_en) writes++;
            if (e_p) e_writes++;
            if (c == j.rst_at) reset = 1'b1;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        valid_in = '0;

        chk("done_pulses", dones, (j.rst_at >= 0) ? 0 : 1);
        chk("done_cycle", done_cyc, (j.rst_at >= 0) ? -1 : ((j.exp_done >= 0) ? j.exp_done : d));
        chk("psum_writes", writes, (j.exp_writes >= 0) ? j.exp_writes : e_writes);
        $display("job n_nij=%0d gap<=%0d rst_at=%0d done@%0d writes=%0d",
                 j.n, j.maxgap, j.rst_at, done_cyc, writes);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        job_t tbl [7];
        job_t rj;
        tbl[0] = '{n: 36, maxgap: 0, spur_start: 1'b1, rst_at: -1, exp_done: 55, exp_writes: 36};
        tbl[1] = '{n: 36, maxgap: 3, spur_start: 1'b0, rst_at: -1, exp_done: -1, exp_writes: 36};
        tbl[2] = '{n: 0,  maxgap: 0, spur_start: 1'b0, rst_at: -1, exp_done: 18, exp_writes: 0};
        tbl[3] = '{n: 4,  maxgap: 0, spur_start: 1'b0, rst_at: -1, exp_done: 23, exp_writes: 4};
        tbl[4] = '{n: 1,  maxgap: 0, spur_start: 1'b1, rst_at: -1, exp_done: 20, exp_writes: 1};
        tbl[5] = '{n: 36, maxgap: 2, spur_start: 1'b0, rst_at: 25, exp_done: -1, exp_writes: -1};
        tbl[6] = '{n: 4,  maxgap: 0, spur_start: 1'b0, rst_at: -1, exp_done: 23, exp_writes: 4};

        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs",
            {busy, done, w_rd_en, w_rd_addr, a_rd_en, a_rd_addr, inst_w, psum_wr_en, psum_wr_addr}, 0);
`ifdef MAC_CTRL_PERF_CNT_EN
        chk("perf_reset", perf_cycles, 0);
`endif
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) run_job(tbl[i]);

        for (int i = 0; i < 4; i++) begin
            rj = '{n: int'($urandom_range(40, 1)), maxgap: int'($urandom_range(3, 0)),
                   spur_start: 1'($urandom_range(1, 0)), rst_at: -1, exp_done: -1, exp_writes: -1};
            run_job(rj);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mac_array_ctrl.md
MAC_ARRAY_CTRL -- requirements
Module: mac_array_ctrl

Interface
REQ-001 SHALL have parameter: row, 8, MAC array rows (weight vector lanes).
REQ-002 SHALL have parameter: col, 8, MAC array columns (weight load beats).
REQ-003 SHALL have parameter: aw, 11, SRAM address width; n_nij max = 2^aw-1.
REQ-004 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port: start  input  1  one-cycle job request, sampled only in IDLE.
REQ-007 SHALL have port: n_nij  input  aw  activation vector count, captured when start accepted.
REQ-008 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port: done  output  1  one-cycle pulse at job end.
REQ-010 SHALL have port: w_rd_en, w_rd_addr  output  1, aw  weight SRAM read.
REQ-011 SHALL have port: a_rd_en, a_rd_addr  output  1, aw  activation SRAM read.
REQ-012 SHALL have port: inst_w  output  2  to array; [0] kernel load, [1] execute.
REQ-013 SHALL have port: valid_in  input  col  array valid; only bit col-1 used.
REQ-014 SHALL have port: psum_wr_en, psum_wr_addr  output  1, aw  psum SRAM write.

Function
REQ-015 SHALL implement states IDLE, LOAD_W, GAP, EXEC, DRAIN, DONE.
REQ-016 SHALL leave IDLE on start; captures n_nij; enters LOAD_W next cycle.
REQ-017 SHALL in LOAD_W assert w_rd_en exactly col cycles, w_rd_addr 0..col-1; then GAP.
REQ-018 SHALL hold GAP col cycles with no reads; then EXEC, or DRAIN-skip to DONE if n_nij==0.
REQ-019 SHALL in EXEC assert a_rd_en n_nij cycles, a_rd_addr 0..n_nij-1; then DRAIN.
REQ-020 SHALL drive inst_w as the read phase delayed one cycle (SRAM latency 1): 01 one cycle after each w_rd_en, 10 one cycle after each a_rd_en, else 00; registered output.
REQ-021 SHALL in EXEC and DRAIN count beats of valid_in[col-1]; each beat asserts psum_wr_en same cycle with psum_wr_addr = beat index 0..n_nij-1.
REQ-022 SHALL leave DRAIN when beat count reaches n_nij; beats beyond n_nij and beats outside EXEC/DRAIN ignored (no write).
REQ-023 SHALL spend exactly one cycle in DONE with done=1, then IDLE.
REQ-024 SHALL ignore start while busy; start in same cycle as DONE ignored.
REQ-025 SHALL keep addresses/counters at aw bits, no wrap within a legal job.

Reset
REQ-026 SHALL on reset low, asynchronously: state IDLE, all counters 0, busy/done/rd_en/psum_wr_en 0, inst_w 00, addresses 0.
REQ-027 SHALL on reset mid-job abandon job; no further reads/writes until new start after release.

Configuration
REQ-028 SHALL with MAC_CTRL_PERF_CNT_EN defined add output perf_cycles (32 bit): cycles from start acceptance to done inclusive, cleared on accept, held after done, 0 on reset.
REQ-029 SHALL without MAC_CTRL_PERF_CNT_EN have no perf_cycles port and no counter logic.

Structure
REQ-030 SHALL place state enum and inst_w encodings (INST_IDLE 00, INST_LOAD 01, INST_EXEC 10) in package mac_ctrl_pkg.
REQ-031 SHALL use one sub-module mac_ctrl_cnt (loadable aw-bit up-counter with clear, enable, terminal compare) for the read and beat counters.

Verification
REQ-032 SHALL cover: row=col=8, start with n_nij=36 at cycle 0 -> w_rd_en cycles 1-8 addr 0-7, inst_w=01 cycles 2-9, a_rd_en cycles 17-52, inst_w=10 cycles 18-53.
REQ-033 SHALL cover: model returns 36 valid_in[7] beats with random gaps -> 36 psum writes addr 0-35, done one cycle after 36th beat, busy low after.
REQ-034 SHALL cover: n_nij=0 -> 8 load cycles, 8 GAP cycles, no a_rd_en, no psum writes, done cycle 18.
REQ-035 SHALL cover: start pulsed during EXEC and during DONE -> ignored, single done pulse.
REQ-036 SHALL cover: reset low at cycle 25 of a job -> outputs zero that cycle, IDLE; restart n_nij=4 completes with 4 writes.
REQ-037 SHALL cover: MAC_CTRL_PERF_CNT_EN, n_nij=4, immediate beats -> perf_cycles equals start-to-done cycle count, holds until next accept.
